// File: rtl/sky130_fd_io__xres_pkg.sv
// Shared types and constants for the XRES reset conditioner.
// Holds the sequencer state encoding, default thresholds and a counter-width helper.
package sky130_fd_io__xres_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } seq_state_e;

  localparam int DEF_NUM_DOM           = 3;
  localparam int DEF_FILT_ASSERT_CYC   = 4;
  localparam int DEF_FILT_DEASSERT_CYC = 16;
  localparam int DEF_STAGE_GAP         = 8;
  localparam int DEF_GLITCH_CNT_W      = 8;

  // Bits needed to hold values 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sky130_fd_io__xres_filt.sv
// Two-flop synchroniser plus asymmetric run-length filter for the pad reset.
// Emits single-cycle pulses for filtered edges and for rejected glitches.
module sky130_fd_io__xres_filt
  import sky130_fd_io__xres_pkg::*;
#(
  parameter int FILT_ASSERT_CYC   = DEF_FILT_ASSERT_CYC,
  parameter int FILT_DEASSERT_CYC = DEF_FILT_DEASSERT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic xres_h_n,
  output logic xres_sync_n,
  output logic xres_filt_n,
  output logic filt_rise,
  output logic filt_fall,
  output logic glitch
);

  localparam int MAX_CYC = (FILT_ASSERT_CYC > FILT_DEASSERT_CYC) ? FILT_ASSERT_CYC
                                                                 : FILT_DEASSERT_CYC;
  localparam int CW = cnt_w(MAX_CYC);
  localparam logic [CW-1:0] THR_A   = CW'(FILT_ASSERT_CYC);
  localparam logic [CW-1:0] THR_D   = CW'(FILT_DEASSERT_CYC);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_CYC);

  logic          meta;
  logic [CW-1:0] run_cnt, run_cnt_nxt, thr;
  logic          differ, flip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta        <= 1'b0;
      xres_sync_n <= 1'b0;
      xres_filt_n <= 1'b0;
      run_cnt     <= '0;
    end else begin
      meta        <= xres_h_n;
      xres_sync_n <= meta;
      xres_filt_n <= xres_filt_n ^ flip;
      run_cnt     <= run_cnt_nxt;
    end
  end

  // Flip on the edge where this sample would bring the run up to the threshold.
  always_comb begin
    thr         = xres_filt_n ? THR_A : THR_D;
    differ      = (xres_sync_n != xres_filt_n);
    flip        = differ && (run_cnt >= (thr - CW'(1)));
    glitch      = !differ && (run_cnt != '0);
    filt_rise   = flip && !xres_filt_n;
    filt_fall   = flip && xres_filt_n;
    run_cnt_nxt = run_cnt;
    if (!differ || flip)
      run_cnt_nxt = '0;
    else if (run_cnt != CNT_MAX)
      run_cnt_nxt = run_cnt + CW'(1);
  end

endmodule

// File: rtl/sky130_fd_io__xres_rst_seq.sv
// XRES reset conditioner: filtered pad reset drives a staggered, thermometer-coded
// release of NUM_DOM core reset domains, with a saturating glitch counter for debug.
module sky130_fd_io__xres_rst_seq
  import sky130_fd_io__xres_pkg::*;
#(
  parameter int NUM_DOM           = DEF_NUM_DOM,
  parameter int FILT_ASSERT_CYC   = DEF_FILT_ASSERT_CYC,
  parameter int FILT_DEASSERT_CYC = DEF_FILT_DEASSERT_CYC,
  parameter int STAGE_GAP         = DEF_STAGE_GAP,
  parameter int GLITCH_CNT_W      = DEF_GLITCH_CNT_W
) (
  input  logic                    CLK,
  input  logic                    RESET_B,
  input  logic                    XRES_H_N,
  input  logic                    GLITCH_CLR,
  output logic                    XRES_SYNC_N,
  output logic                    XRES_FILT_N,
  output logic [NUM_DOM-1:0]      RST_N_DOM,
  output logic                    SEQ_DONE,
  output logic [GLITCH_CNT_W-1:0] GLITCH_CNT
);

  localparam int GW = cnt_w(STAGE_GAP);
  localparam logic [GW-1:0]      GAP_LAST = GW'(STAGE_GAP - 1);
  localparam logic [NUM_DOM-1:0] DOM_ONE  = NUM_DOM'(1);

  seq_state_e         state, state_nxt;
  logic [GW-1:0]      gap, gap_nxt;
  logic [NUM_DOM-1:0] dom, dom_nxt;
  logic               done, done_nxt;
  logic               filt_rise, filt_fall, glitch;

  sky130_fd_io__xres_filt #(
    .FILT_ASSERT_CYC  (FILT_ASSERT_CYC),
    .FILT_DEASSERT_CYC(FILT_DEASSERT_CYC)
  ) u_filt (
    .clk        (CLK),
    .rst_n      (RESET_B),
    .xres_h_n   (XRES_H_N),
    .xres_sync_n(XRES_SYNC_N),
    .xres_filt_n(XRES_FILT_N),
    .filt_rise  (filt_rise),
    .filt_fall  (filt_fall),
    .glitch     (glitch)
  );

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state <= ST_HOLD;
      gap   <= '0;
      dom   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      gap   <= gap_nxt;
      dom   <= dom_nxt;
      done  <= done_nxt;
    end
  end

  // Domains release by shifting a 1 into the low end, so the vector stays
  // thermometer-coded and the next bit to set is implicit.
  always_comb begin
    state_nxt = state;
    gap_nxt   = gap;
    dom_nxt   = dom;
    done_nxt  = done;
    if (filt_fall) begin
      state_nxt = ST_HOLD;
      gap_nxt   = '0;
      dom_nxt   = '0;
      done_nxt  = 1'b0;
    end else begin
      case (state)
        ST_HOLD: begin
          dom_nxt  = '0;
          done_nxt = 1'b0;
          if (filt_rise) begin
            state_nxt = ST_RELEASE;
            gap_nxt   = '0;
          end
        end
        ST_RELEASE: begin
          if (gap == GAP_LAST) begin
            gap_nxt = '0;
            dom_nxt = (dom << 1) | DOM_ONE;
            if (dom_nxt[NUM_DOM-1]) begin
              state_nxt = ST_RUN;
              done_nxt  = 1'b1;
            end
          end else begin
            gap_nxt = gap + GW'(1);
          end
        end
        ST_RUN:  done_nxt = 1'b1;
        default: begin
          state_nxt = ST_HOLD;
          dom_nxt   = '0;
          done_nxt  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B)
      GLITCH_CNT <= '0;
    else if (GLITCH_CLR)
      GLITCH_CNT <= '0;
    else if (glitch && (GLITCH_CNT != '1))
      GLITCH_CNT <= GLITCH_CNT + GLITCH_CNT_W'(1);
  end

  assign RST_N_DOM = dom;
  assign SEQ_DONE  = done;

endmodule

// File: tb/tb_sky130_fd_io__xres_rst_seq.sv
// Bench for the XRES reset conditioner: directed vector table, glitch saturation,
// randomized pad activity against a window-based reference model, async reset.
module tb_sky130_fd_io__xres_rst_seq;

  localparam int ND = 3, FA = 4, FD = 16, GAP = 8, GW = 8;

  logic          CLK, RESET_B, XRES_H_N, GLITCH_CLR;
  logic          XRES_SYNC_N, XRES_FILT_N, SEQ_DONE;
  logic [ND-1:0] RST_N_DOM;
  logic [GW-1:0] GLITCH_CNT;

  sky130_fd_io__xres_rst_seq #(
    .NUM_DOM(ND), .FILT_ASSERT_CYC(FA), .FILT_DEASSERT_CYC(FD),
    .STAGE_GAP(GAP), .GLITCH_CNT_W(GW)
  ) dut (
    .CLK(CLK), .RESET_B(RESET_B), .XRES_H_N(XRES_H_N), .GLITCH_CLR(GLITCH_CLR),
    .XRES_SYNC_N(XRES_SYNC_N), .XRES_FILT_N(XRES_FILT_N), .RST_N_DOM(RST_N_DOM),
    .SEQ_DONE(SEQ_DONE), .GLITCH_CNT(GLITCH_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0, n_err = 0;

  // Reference model: p[e] = pad sampled at edge e, y[e] = synced level after edge e.
  // Filter flips when the last N synced samples since the previous flip all disagree.
  bit p[0:8191];
  bit y[0:8191];
  int e, t_flip, r_edge, m_gcnt;
  bit m_filt;

  task automatic model_reset();
    e = 0; p[0] = 1'b0; y[0] = 1'b0;
    t_flip = 0; r_edge = 0; m_filt = 1'b0; m_gcnt = 0;
  endtask

  task automatic model_edge(input bit pad, input bit clr);
    int  n;
    bit  all_diff, flip, gl;
    e++;
    p[e] = pad;
    y[e] = p[e-1];
    n = m_filt ? FA : FD;
    flip = 1'b0;
    if (e - n >= t_flip) begin
      all_diff = 1'b1;
      for (int k = e - n; k < e; k++)
        if (y[k] == m_filt) all_diff = 1'b0;
      flip = all_diff;
    end
    gl = (e >= 2) && (e - 2 >= t_flip) && (y[e-1] == m_filt) && (y[e-2] != m_filt);
    if (flip) begin
      m_filt = !m_filt;
      t_flip = e;
      if (m_filt) r_edge = e;
    end
    if (clr) m_gcnt = 0;
    else if (gl && m_gcnt < 255) m_gcnt++;
  endtask

  function automatic int exp_dom();
    int d = 0;
    if (m_filt)
      for (int i = 0; i < ND; i++)
        if (e - r_edge >= GAP * (i + 1)) d |= (1 << i);
    return d;
  endfunction

  function automatic int exp_done();
    return (m_filt && (e - r_edge >= GAP * ND)) ? 1 : 0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", nm, act, exp, e, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge(XRES_H_N, GLITCH_CLR);
    #1;
    chk("model.sync", int'(XRES_SYNC_N), int'(y[e]));
    chk("model.filt", int'(XRES_FILT_N), int'(m_filt));
    chk("model.dom",  int'(RST_N_DOM),   exp_dom());
    chk("model.done", int'(SEQ_DONE),    exp_done());
    chk("model.gcnt", int'(GLITCH_CNT),  m_gcnt);
  endtask

  typedef struct {
    int pad; int clr; int cyc;
    int filt; int dom; int done; int gcnt;
  } vec_t;
  vec_t tbl[20];

  task automatic run_vec(input int i);
    XRES_H_N   = 1'(tbl[i].pad);
    GLITCH_CLR = 1'(tbl[i].clr);
    repeat (tbl[i].cyc) tick();
    chk($sformatf("vec%0d.filt", i), int'(XRES_FILT_N), tbl[i].filt);
    chk($sformatf("vec%0d.dom",  i), int'(RST_N_DOM),   tbl[i].dom);
    chk($sformatf("vec%0d.done", i), int'(SEQ_DONE),    tbl[i].done);
    chk($sformatf("vec%0d.gcnt", i), int'(GLITCH_CNT),  tbl[i].gcnt);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".sync"}, int'(XRES_SYNC_N), 0);
    chk({tag, ".filt"}, int'(XRES_FILT_N), 0);
    chk({tag, ".dom"},  int'(RST_N_DOM),   0);
    chk({tag, ".done"}, int'(SEQ_DONE),    0);
    chk({tag, ".gcnt"}, int'(GLITCH_CNT),  0);
  endtask

  initial begin
    // power-up: filter rises 18 edges after reset release, domains at +8/+16/+24
    tbl[0]  = '{1, 0, 17, 0, 0, 0, 0};
    tbl[1]  = '{1, 0,  1, 1, 0, 0, 0};
    tbl[2]  = '{1, 0,  7, 1, 0, 0, 0};
    tbl[3]  = '{1, 0,  1, 1, 1, 0, 0};
    tbl[4]  = '{1, 0,  8, 1, 3, 0, 0};
    tbl[5]  = '{1, 0,  8, 1, 7, 1, 0};
    // three-sample glitch, counted when sync returns high, then cleared
    tbl[6]  = '{0, 0,  3, 1, 7, 1, 0};
    tbl[7]  = '{1, 0,  2, 1, 7, 1, 0};
    tbl[8]  = '{1, 0,  1, 1, 7, 1, 1};
    tbl[9]  = '{1, 1,  1, 1, 7, 1, 0};
    // valid reset: falls on the 6th edge, everything low together
    tbl[10] = '{0, 0,  5, 1, 7, 1, 0};
    tbl[11] = '{0, 0,  1, 0, 0, 0, 0};
    tbl[12] = '{0, 0,  4, 0, 0, 0, 0};
    // release up to first domain, then abort
    tbl[13] = '{1, 0, 17, 0, 0, 0, 0};
    tbl[14] = '{1, 0,  1, 1, 0, 0, 0};
    tbl[15] = '{1, 0,  7, 1, 0, 0, 0};
    tbl[16] = '{1, 0,  1, 1, 1, 0, 0};
    tbl[17] = '{0, 0,  5, 1, 1, 0, 0};
    tbl[18] = '{0, 0,  1, 0, 0, 0, 0};
    tbl[19] = '{0, 0,  3, 0, 0, 0, 0};

    RESET_B = 1'b0; XRES_H_N = 1'b1; GLITCH_CLR = 1'b0;
    model_reset();
    repeat (5) @(posedge CLK);
    #1;
    chk_reset_vals("por");
    RESET_B = 1'b1;

    for (int i = 0; i < 20; i++) run_vec(i);
    // re-release after abort restarts from bit 0 with full gaps
    for (int i = 0; i < 6; i++) run_vec(i);

    // saturation: 300 glitches must pin the counter at all-ones
    for (int g = 0; g < 300; g++) begin
      XRES_H_N = 1'b0; repeat (3) tick();
      XRES_H_N = 1'b1; repeat (3) tick();
    end
    chk("sat.gcnt", int'(GLITCH_CNT), 255);
    chk("sat.filt", int'(XRES_FILT_N), 1);
    chk("sat.dom",  int'(RST_N_DOM), 7);
    XRES_H_N = 1'b0; repeat (3) tick();
    XRES_H_N = 1'b1; repeat (2) tick();
    GLITCH_CLR = 1'b1; tick();
    chk("clr_vs_inc.gcnt", int'(GLITCH_CNT), 0);
    GLITCH_CLR = 1'b0; tick();

    // random pad runs and sporadic clears against the model
    for (int r = 0; r < 150; r++) begin
      XRES_H_N = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 24)) begin
        GLITCH_CLR = ($urandom_range(0, 15) == 0);
        tick();
      end
    end
    GLITCH_CLR = 1'b0;

    // async reset in the middle of a release
    XRES_H_N = 1'b0; repeat (10) tick();
    XRES_H_N = 1'b1; repeat (26) tick();
    chk("pre_async.dom", int'(RST_N_DOM), 1);
    #1 RESET_B = 1'b0;
    #1 chk_reset_vals("async");
    #4 RESET_B = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) run_vec(i);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sky130_fd_io__xres_rst_seq.md
Name: sky130_fd_io__xres_rst_seq

Overview:
Digital reset conditioner that sits directly downstream of the XRES pad cell and consumes its XRES_H_N output after level shifting into the core domain.
- Synchronises the asynchronous pad reset into CLK.
- Qualifies it with separate assert and deassert filter counts.
- Releases NUM_DOM core reset domains in a fixed staggered order.
- Counts rejected glitches for debug visibility.

Parameters:
NUM_DOM, 3, number of sequenced core reset domains (1..8)
FILT_ASSERT_CYC, 4, consecutive low synced samples needed to assert filtered reset (>=1)
FILT_DEASSERT_CYC, 16, consecutive high synced samples needed to deassert filtered reset (>=1)
STAGE_GAP, 8, CLK cycles between successive domain releases (>=1)
GLITCH_CNT_W, 8, width of the saturating glitch counter

Ports:
CLK  input  1  core clock
RESET_B  input  1  asynchronous active-low reset (POR-derived)
XRES_H_N  input  1  asynchronous pad reset from the XRES cell, active low
GLITCH_CLR  input  1  synchronous clear of GLITCH_CNT
XRES_SYNC_N  output  1  two-flop synchronised XRES_H_N
XRES_FILT_N  output  1  filtered reset level, active low
RST_N_DOM  output  NUM_DOM  per-domain active-low resets; bit 0 is released first
SEQ_DONE  output  1  high when all domains are released
GLITCH_CNT  output  GLITCH_CNT_W  saturating count of rejected pulses

Behaviour:
- Clock and reset: one clock, CLK. RESET_B is asynchronous and active-low.
- Reset values (RESET_B low): sync flops 0, XRES_SYNC_N 0, XRES_FILT_N 0, RST_N_DOM all 0, SEQ_DONE 0, GLITCH_CNT 0, FSM in HOLD, run counter 0.
- Synchroniser:
  - Two flops, reset to 0.
  - XRES_SYNC_N reflects XRES_H_N two CLK edges after the first sampling edge.
- Filter:
  - A run counter counts consecutive cycles in which XRES_SYNC_N != XRES_FILT_N.
  - It clears to 0 on any cycle where the two are equal.
  - When the count reaches FILT_ASSERT_CYC (if XRES_FILT_N is 1) or FILT_DEASSERT_CYC (if XRES_FILT_N is 0), XRES_FILT_N flips on that edge and the counter clears.
  - The counter saturates at the max threshold and never wraps.
- Glitch detection:
  - Condition: the run counter is nonzero and XRES_SYNC_N returns equal to XRES_FILT_N before the threshold is reached.
  - Effect: GLITCH_CNT increments by 1, saturating at all-ones.
  - GLITCH_CLR takes priority over an increment in the same cycle, giving 0.
- FSM states: HOLD, RELEASE, RUN.
  - HOLD: all RST_N_DOM 0. On XRES_FILT_N rising → RELEASE with stage index 0 and gap counter 0.
  - RELEASE: the gap counter counts to STAGE_GAP. When it reaches STAGE_GAP, RST_N_DOM[idx] is set to 1, idx increments and the gap counter clears. After the last bit is set → RUN.
  - Release timing: RST_N_DOM[i] rises exactly STAGE_GAP*(i+1) cycles after the XRES_FILT_N rising edge.
  - RUN: SEQ_DONE is 1, registered, and rises with RST_N_DOM[NUM_DOM-1].
- Assertion priority: XRES_FILT_N falling from any state drives all RST_N_DOM to 0 and SEQ_DONE to 0 on the same edge, and the FSM goes to HOLD. This also aborts a partial release.
- Ordering invariant: RST_N_DOM is thermometer-coded at all times (bit i high implies every lower bit high).
- Latency:
  - Assertion latency from the XRES_H_N fall to RST_N_DOM low is 2 + FILT_ASSERT_CYC edges.
  - Release latency from the XRES_H_N rise to RST_N_DOM[0] high is 2 + FILT_DEASSERT_CYC + STAGE_GAP edges.
- Start-up: RESET_B deasserting with XRES_H_N already high follows the normal deassert path; no shortcut.
- X handling: none. The inputs are digital and already level-shifted.

Decomposition:
- Shared package sky130_fd_io__xres_pkg holds:
  - the FSM state enum (HOLD, RELEASE, RUN);
  - a clog2-based counter width helper;
  - default threshold constants.
- One sub-module, sky130_fd_io__xres_filt: the synchroniser, run counter, filter and glitch pulse output. The top level holds the sequencer FSM and GLITCH_CNT.

Test Plan:
- Power-up: hold RESET_B low 5 cycles with XRES_H_N=1, then release.
  → XRES_FILT_N rises at edge 18 (2+16).
  → RST_N_DOM goes 001 / 011 / 111 at +8 / +16 / +24 cycles.
  → SEQ_DONE rises with RST_N_DOM=111.
- Glitch rejection: in RUN, pulse XRES_H_N low for 3 synced cycles.
  → XRES_FILT_N stays 1, RST_N_DOM stays 111, GLITCH_CNT becomes 1.
  Then GLITCH_CLR pulse → GLITCH_CNT 0.
- Valid reset: in RUN, drive XRES_H_N low 10 cycles.
  → XRES_FILT_N falls 6 edges (2+4) after the first sampling edge.
  → RST_N_DOM=000 and SEQ_DONE=0 on that same edge.
- Abort mid-release: assert a valid reset while RST_N_DOM=001.
  → all bits go to 0 and the FSM is in HOLD.
  On re-release, the sequence restarts from bit 0 with full gaps.
- Saturation: inject 300 three-cycle glitches.
  → GLITCH_CNT holds 255 with no wrap.
  → GLITCH_CLR in the same cycle as a glitch gives 0.
- Async reset mid-RELEASE: pulse RESET_B low for a half cycle.
  → all outputs reach reset values immediately without waiting for a CLK edge, then the power-up timing repeats.
